// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares one register-file write port between the load-return
// path and a FIFO-buffered ALU result path. Loads have priority, and a streak limit forces ALU progress.
module wb_port_arbiter #(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned MAX_LD_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(MAX_LD_STREAK + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic {LD_PRI, ALU_FORCE} state_t;

    state_t          state, next_state;
    logic [SW-1:0]   streak, streak_next;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    wb_entry_t       fifo [DEPTH];

    logic            push, pop, bypass, grant;
    wb_entry_t       grant_entry;
    logic            fifo_nonempty;

    assign fifo_nonempty = (count != '0);

    // Grant selection, FIFO handshake and streak tracking
    always_comb begin
        next_state  = state;
        streak_next = streak;
        ld_ready    = 1'b0;
        pop         = 1'b0;
        bypass      = 1'b0;
        grant       = 1'b0;
        grant_entry = '0;
        case (state)
            LD_PRI: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    grant       = 1'b1;
                    grant_entry = '{rd: ld_rd, data: ld_data};
                    if (fifo_nonempty) begin
                        streak_next = streak + SW'(1);
                        if (streak_next == SW'(MAX_LD_STREAK)) begin
                            next_state = ALU_FORCE;
                        end
                    end else begin
                        streak_next = '0;
                    end
                end else if (fifo_nonempty) begin
                    pop         = 1'b1;
                    grant       = 1'b1;
                    grant_entry = fifo[rd_ptr];
                    streak_next = '0;
                end else begin
                    streak_next = '0;
                    if (alu_valid) begin
                        bypass      = 1'b1;
                        grant       = 1'b1;
                        grant_entry = '{rd: alu_rd, data: alu_result};
                    end
                end
            end
            ALU_FORCE: begin
                next_state  = LD_PRI;
                streak_next = '0;
                if (fifo_nonempty) begin
                    pop         = 1'b1;
                    grant       = 1'b1;
                    grant_entry = fifo[rd_ptr];
                end
            end
        endcase
        alu_ready = (count < CW'(DEPTH)) || pop;
        push      = alu_valid && alu_ready && !bypass;
    end

    assign busy = fifo_nonempty || rf_we;

    // State, pointers and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LD_PRI;
            streak <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
        end else begin
            state  <= next_state;
            streak <= streak_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count  <= count + CW'(push) - CW'(pop);
            rf_we  <= grant && (grant_entry.rd != 5'd0);
            if (grant && (grant_entry.rd != 5'd0)) begin
                rf_wa <= grant_entry.rd;
                rf_wd <= grant_entry.data;
            end
        end
    end

    // Result storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{rd: alu_rd, data: alu_result};
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int MAXS  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, ld_valid;
    logic [4:0]  alu_rd, ld_rd;
    logic [31:0] alu_result, ld_data;
    logic        alu_ready, ld_ready, rf_we, busy;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int errors = 0;
    int checks = 0;

    wb_port_arbiter #(.DEPTH(DEPTH), .MAX_LD_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: pending ALU results as a queue, loads counted as a streak
    logic [36:0] q[$];
    int          m_streak;
    bit          m_force;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        exp_ld_ready, exp_alu_ready;
    logic        obs_ld_ready, obs_alu_ready;

    task automatic model_reset();
        q.delete();
        m_streak = 0;
        m_force  = 0;
        m_we     = 0;
        m_wa     = '0;
        m_wd     = '0;
    endtask

    task automatic model_step();
        int          sz = q.size();
        bit          have = 0, popped = 0, byp = 0, load_win = 0;
        logic [36:0] g = '0;
        exp_ld_ready = !m_force;
        if (m_force) begin
            m_force  = 0;
            m_streak = 0;
            if (sz > 0) begin g = q.pop_front(); have = 1; popped = 1; end
        end else begin
            if (ld_valid) begin g = {ld_rd, ld_data}; have = 1; load_win = 1; end
            else if (sz > 0) begin g = q.pop_front(); have = 1; popped = 1; end
            else if (alu_valid) begin g = {alu_rd, alu_result}; have = 1; byp = 1; end
            if (load_win && sz > 0) begin
                m_streak++;
                if (m_streak == MAXS) begin m_force = 1; m_streak = 0; end
            end else begin
                m_streak = 0;
            end
        end
        exp_alu_ready = (sz < DEPTH) || popped;
        if (alu_valid && exp_alu_ready && !byp) q.push_back({alu_rd, alu_result});
        m_we = have && (g[36:32] != 5'd0);
        if (m_we) begin m_wa = g[36:32]; m_wd = g[31:0]; end
    endtask

    // One clock of stimulus; readies sampled mid-cycle, write port sampled just after the edge
    task automatic drive_cycle(input bit lv, input logic [4:0] lr, input logic [31:0] ldd,
                               input bit av, input logic [4:0] ar, input logic [31:0] ad);
        @(negedge clk);
        ld_valid = lv; ld_rd = lr; ld_data = ldd;
        alu_valid = av; alu_rd = ar; alu_result = ad;
        #1;
        obs_ld_ready  = ld_ready;
        obs_alu_ready = alu_ready;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld_valid = 0; ld_rd = '0; ld_data = '0;
        alu_valid = 0; alu_rd = '0; alu_result = '0;
        model_reset();
        #12;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        checks++; if (rf_wa !== 5'd0 || rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_addr_data got=%h/%h exp=0/0", rf_wa, rf_wd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL reset_readies got=%b%b exp=11", ld_ready, alu_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        drive_cycle(0, 5'd0, 32'd0, 1, 5'd3, 32'h11);
        checks++; if (obs_alu_ready !== 1'b1) begin errors++; $display("FAIL bypass_alu_ready got=%b exp=1", obs_alu_ready); end
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h11) begin
            errors++; $display("FAIL bypass_write got=%b/%0d/%h exp=1/3/11", rf_we, rf_wa, rf_wd); end
        idle(1);
        checks++; if (busy !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL bypass_no_fifo got=busy%b we%b exp=0/0", busy, rf_we); end
    endtask

    task automatic test_simultaneous();
        drive_cycle(1, 5'd5, 32'hAA, 1, 5'd6, 32'hBB);
        checks++; if (obs_alu_ready !== 1'b1 || obs_ld_ready !== 1'b1) begin
            errors++; $display("FAIL simul_readies got=%b%b exp=11", obs_ld_ready, obs_alu_ready); end
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hAA) begin
            errors++; $display("FAIL simul_load_first got=%b/%0d/%h exp=1/5/aa", rf_we, rf_wa, rf_wd); end
        idle(1);
        checks++; if (obs_alu_ready !== 1'b1) begin errors++; $display("FAIL simul_alu_ready2 got=%b exp=1", obs_alu_ready); end
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd6 || rf_wd !== 32'hBB) begin
            errors++; $display("FAIL simul_alu_second got=%b/%0d/%h exp=1/6/bb", rf_we, rf_wa, rf_wd); end
        idle(1);
    endtask

    task automatic test_streak();
        int li = 1, alu_w = 0, ld_w = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            drive_cycle(li <= 10, 5'(li), 32'h100 + 32'(li), cyc < 2, 5'(20 + cyc), 32'h200 + 32'(cyc));
            if (exp_ld_ready && li <= 10) li++;
            if (cyc == 2) begin
                checks++; if (obs_alu_ready !== 1'b0) begin errors++; $display("FAIL streak_full_alu_ready got=%b exp=0", obs_alu_ready); end
            end
            if (cyc == 5) begin
                checks++; if (obs_ld_ready !== 1'b0) begin errors++; $display("FAIL streak_force_ld_ready got=%b exp=0", obs_ld_ready); end
                checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd20 || rf_wd !== 32'h200) begin
                    errors++; $display("FAIL streak_force_write got=%b/%0d/%h exp=1/20/200", rf_we, rf_wa, rf_wd); end
            end
            if (rf_we === 1'b1 && rf_wa >= 5'd20) alu_w++;
            else if (rf_we === 1'b1) ld_w++;
        end
        checks++; if (alu_w != 2 || ld_w != 10) begin errors++; $display("FAIL streak_totals got=alu%0d ld%0d exp=alu2 ld10", alu_w, ld_w); end
    endtask

    task automatic test_full_push_pop();
        drive_cycle(1, 5'd9, 32'h9, 1, 5'd10, 32'hA0);
        drive_cycle(1, 5'd11, 32'hB, 1, 5'd12, 32'hA1);
        drive_cycle(0, 5'd0, 32'd0, 1, 5'd13, 32'hA2);
        checks++; if (obs_alu_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_ready got=%b exp=1", obs_alu_ready); end
        checks++; if (rf_wa !== 5'd10 || rf_wd !== 32'hA0) begin errors++; $display("FAIL full_pushpop_head got=%0d/%h exp=10/a0", rf_wa, rf_wd); end
        idle(1);
        checks++; if (rf_wa !== 5'd12 || rf_wd !== 32'hA1) begin errors++; $display("FAIL full_order_2 got=%0d/%h exp=12/a1", rf_wa, rf_wd); end
        idle(1);
        checks++; if (rf_wa !== 5'd13 || rf_wd !== 32'hA2) begin errors++; $display("FAIL full_order_3 got=%0d/%h exp=13/a2", rf_wa, rf_wd); end
        idle(1);
    endtask

    task automatic test_r0();
        drive_cycle(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'd0);
        checks++; if (obs_ld_ready !== 1'b1) begin errors++; $display("FAIL r0_ld_ready got=%b exp=1", obs_ld_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_no_write got=%b exp=0", rf_we); end
        drive_cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h77);
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h77) begin
            errors++; $display("FAIL r0_next_alu got=%b/%0d/%h exp=1/7/77", rf_we, rf_wa, rf_wd); end
        idle(1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 99) < 55, 5'($urandom_range(0, 31)), $urandom,
                        $urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom);
            checks++; if (obs_ld_ready !== exp_ld_ready || obs_alu_ready !== exp_alu_ready) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", i, obs_ld_ready, obs_alu_ready, exp_ld_ready, exp_alu_ready); end
            checks++; if (rf_we !== m_we || rf_wa !== m_wa || rf_wd !== m_wd) begin
                errors++; $display("FAIL rand_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we, rf_wa, rf_wd, m_we, m_wa, m_wd); end
            checks++; if (busy !== ((q.size() != 0) || m_we)) begin
                errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, busy, (q.size() != 0) || m_we); end
        end
        idle(6);
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        drive_cycle(1, 5'd3, 32'h3, 1, 5'd4, 32'h4);
        checks++; if (busy !== 1'b1 || rf_we !== 1'b1) begin errors++; $display("FAIL mid_pre got=busy%b we%b exp=1/1", busy, rf_we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin
            errors++; $display("FAIL mid_async_clear got=%b/%0d/%h exp=0/0/0", rf_we, rf_wa, rf_wd); end
        model_reset();
        @(negedge clk);
        ld_valid = 0; alu_valid = 0;
        rst_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || alu_ready !== 1'b1) begin errors++; $display("FAIL mid_after got=busy%b rdy%b exp=0/1", busy, alu_ready); end
        idle(2);
        checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_discarded got=we%b busy%b exp=0/0", rf_we, busy); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_simultaneous();
        test_streak();
        test_full_push_pop();
        test_r0();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
